// File: rtl/datapath_stim_gen.sv
// Flow-controlled stimulus source: per-transfer control word and K constant from
// a seeded LFSR bank or an incrementing counter, with sticky DUT status capture.
module datapath_stim_gen #(
  parameter int unsigned CW_WIDTH    = 23,
  parameter int unsigned K_WIDTH     = 64,
  parameter int unsigned COUNT_WIDTH = 16,
  parameter logic [31:0] SEED        = 32'hACE1_2025
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [1:0]             i_mode,
  input  logic [COUNT_WIDTH-1:0] i_burst_len,
  input  logic                   i_stop,
  input  logic                   i_ready,
  input  logic [3:0]             i_status,
  output logic [CW_WIDTH-1:0]    o_control_word,
  output logic [K_WIDTH-1:0]     o_k,
  output logic                   o_valid,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [COUNT_WIDTH-1:0] o_xfer_count,
  output logic [3:0]             o_status_sticky
);

  localparam int unsigned W_WIDTH = CW_WIDTH + K_WIDTH;
  localparam int unsigned N_LFSR  = (W_WIDTH + 31) / 32;
  localparam int unsigned R_WIDTH = N_LFSR * 32;
  localparam logic [31:0] POLY    = 32'h8020_0003;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  function automatic logic [31:0] f_seed(input int unsigned idx);
    logic [31:0] s;
    s = SEED ^ (32'(idx) * 32'h9E37_79B9);
    if (s == 32'h0) s = 32'h1;
    return s;
  endfunction

  function automatic logic [31:0] f_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  state_t                 r_state;
  logic [31:0]            r_lfsr [N_LFSR];
  logic [W_WIDTH-1:0]     r_inc;
  logic [1:0]             r_mode;
  logic [COUNT_WIDTH-1:0] r_burst_len;
  logic [COUNT_WIDTH-1:0] r_xfer_count;
  logic [3:0]             r_sticky;
  logic                   r_valid;
  logic                   r_busy;
  logic                   r_done;
  logic [CW_WIDTH-1:0]    r_cw;
  logic [K_WIDTH-1:0]     r_k;

  logic [R_WIDTH-1:0]     w_r_nxt;
  logic [R_WIDTH-1:0]     w_r_seed;
  logic [W_WIDTH-1:0]     w_inc_nxt;
  logic [W_WIDTH-1:0]     w_word_seed;
  logic [W_WIDTH-1:0]     w_word_nxt;
  logic [COUNT_WIDTH-1:0] w_cnt_nxt;
  logic                   w_xfer;
  logic                   w_burst_end;
  logic                   w_unused_pad;

  // Concatenated bank views: next-step values and freshly seeded values
  always_comb begin
    w_r_nxt  = '0;
    w_r_seed = '0;
    for (int unsigned i = 0; i < N_LFSR; i++) begin
      w_r_nxt[i*32 +: 32]  = f_step(r_lfsr[i]);
      w_r_seed[i*32 +: 32] = f_seed(i);
    end
  end

  assign w_unused_pad = ^{w_r_nxt, w_r_seed};
  assign w_inc_nxt    = r_inc + W_WIDTH'(1);
  assign w_word_seed  = i_mode[1] ? '0 : w_r_seed[W_WIDTH-1:0];
  assign w_word_nxt   = r_mode[1] ? w_inc_nxt : w_r_nxt[W_WIDTH-1:0];
  assign w_xfer       = r_valid & i_ready;
  assign w_cnt_nxt    = (r_xfer_count == '1) ? r_xfer_count
                                             : r_xfer_count + COUNT_WIDTH'(1);
  assign w_burst_end  = r_mode[0] && (w_cnt_nxt == r_burst_len);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      for (int unsigned i = 0; i < N_LFSR; i++) r_lfsr[i] <= f_seed(i);
      r_inc        <= '0;
      r_mode       <= '0;
      r_burst_len  <= '0;
      r_xfer_count <= '0;
      r_sticky     <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cw         <= '0;
      r_k          <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_stop) begin
            r_state      <= S_RUN;
            r_busy       <= 1'b1;
            for (int unsigned i = 0; i < N_LFSR; i++) r_lfsr[i] <= f_seed(i);
            r_inc        <= '0;
            r_xfer_count <= '0;
            r_sticky     <= '0;
            r_mode       <= i_mode;
            r_burst_len  <= i_burst_len;
            // A zero-length burst presents nothing, so the outputs keep their old word
            if (i_mode[0] && (i_burst_len == '0)) begin
              r_valid <= 1'b0;
            end else begin
              r_valid     <= 1'b1;
              {r_cw, r_k} <= w_word_seed;
            end
          end
        end
        S_RUN: begin
          r_sticky <= r_sticky | i_status;
          if (!r_valid) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            if (w_xfer) begin
              for (int unsigned i = 0; i < N_LFSR; i++) r_lfsr[i] <= f_step(r_lfsr[i]);
              r_inc        <= w_inc_nxt;
              r_xfer_count <= w_cnt_nxt;
            end
            if (i_stop || (w_xfer && w_burst_end)) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else if (w_xfer) begin
              {r_cw, r_k} <= w_word_nxt;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_control_word  = r_cw;
  assign o_k             = r_k;
  assign o_valid         = r_valid;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_xfer_count    = r_xfer_count;
  assign o_status_sticky = r_sticky;

endmodule

// File: tb/tb_datapath_stim_gen.sv
// Scoreboard bench for datapath_stim_gen: expected words are queued at run start
// from a reference LFSR/counter model and popped by a monitor on every transfer.
module tb_datapath_stim_gen;
  localparam int unsigned CW  = 23;
  localparam int unsigned KW  = 64;
  localparam int unsigned CNT = 16;
  localparam int unsigned WW  = CW + KW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [1:0]     mode;
  logic [CNT-1:0] burst_len;
  logic           stop;
  logic           ready;
  logic [3:0]     status;
  logic [CW-1:0]  control_word;
  logic [KW-1:0]  k;
  logic           valid, busy, done;
  logic [CNT-1:0] xfer_count;
  logic [3:0]     status_sticky;

  datapath_stim_gen dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode),
    .i_burst_len(burst_len), .i_stop(stop), .i_ready(ready), .i_status(status),
    .o_control_word(control_word), .o_k(k), .o_valid(valid), .o_busy(busy),
    .o_done(done), .o_xfer_count(xfer_count), .o_status_sticky(status_sticky)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [WW-1:0] q_exp[$];
  logic          rdy_pat[$];
  bit            rand_ready = 1'b0;
  int            valid_cycles = 0;
  int            done_seen = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic next_ready();
    if (rdy_pat.size() > 0) return rdy_pat.pop_front();
    if (rand_ready) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  // Reference model: expected word sequence of a run, straight from the seeding rules
  task automatic push_expected(input logic [1:0] m, input int n);
    logic [31:0] l [3];
    logic [95:0] cat;
    for (int i = 0; i < 3; i++) begin
      l[i] = 32'hACE1_2025 ^ (32'(i) * 32'h9E37_79B9);
      if (l[i] == 32'h0) l[i] = 32'h1;
    end
    for (int j = 0; j < n; j++) begin
      if (m[1]) begin
        q_exp.push_back(WW'(j));
      end else begin
        cat = {l[2], l[1], l[0]};
        q_exp.push_back(cat[WW-1:0]);
      end
      for (int i = 0; i < 3; i++)
        l[i] = l[i][0] ? ((l[i] >> 1) ^ 32'h8020_0003) : (l[i] >> 1);
    end
  endtask

  // Monitor: pops on each transfer and checks words hold while stalled
  logic [WW-1:0] held;
  bit            hold_pending = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (done) done_seen++;
      if (valid) begin
        valid_cycles++;
        if (hold_pending) chk("hold_stable", {control_word, k}, held);
      end
      if (valid && ready) begin
        if (q_exp.size() == 0) chk("unexpected_xfer", 1'b1, 1'b0);
        else chk("word", {control_word, k}, q_exp.pop_front());
        hold_pending = 1'b0;
      end else if (valid) begin
        hold_pending = 1'b1;
        held = {control_word, k};
      end else begin
        hold_pending = 1'b0;
      end
    end
  end

  task automatic do_start(input logic [1:0] m, input logic [CNT-1:0] bl);
    @(posedge clk); #1;
    start = 1'b1; mode = m; burst_len = bl;
    @(posedge clk); #1;
    start = 1'b0;
    ready = next_ready();
  endtask

  task automatic wait_done(input int budget, output int busy_cnt);
    bit saw = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin saw = 1'b1; break; end
      @(posedge clk); #1;
      ready = next_ready();
    end
    chk("done_reached", saw, 1'b1);
    chk("valid_low_in_done", valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    chk("idle_after_done", busy, 1'b0);
  endtask

  int bc;
  logic [1:0]     rm;
  logic [CNT-1:0] rl;

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'b00; burst_len = '0;
    stop = 1'b0; ready = 1'b1; status = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {valid, busy, done, xfer_count, status_sticky, control_word, k}, '0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Random burst of 3: latency, first-word constants, count
    push_expected(2'b01, 3);
    @(posedge clk); #1 start = 1'b1; mode = 2'b01; burst_len = 16'd3;
    @(negedge clk);
    chk("valid_before_start_edge", valid, 1'b0);
    @(posedge clk); #1 start = 1'b0; ready = next_ready();
    @(negedge clk);
    chk("first_valid", valid, 1'b1);
    chk("first_k", k, 64'h32D6_599C_ACE1_2025);
    chk("first_cw", control_word, 23'h0F_D357);
    wait_done(50, bc);
    chk("burst3_count", xfer_count, 16'd3);
    chk("burst3_queue_empty", q_exp.size(), 0);

    // Incrementing burst of 4 with a fixed ready pattern
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    push_expected(2'b11, 4);
    do_start(2'b11, 16'd4);
    wait_done(50, bc);
    chk("inc4_count", xfer_count, 16'd4);
    chk("inc4_queue_empty", q_exp.size(), 0);

    // Same random burst twice: reseed must reproduce the sequence
    for (int r = 0; r < 2; r++) begin
      push_expected(2'b01, 5);
      do_start(2'b01, 16'd5);
      wait_done(50, bc);
      chk("repeat_count", xfer_count, 16'd5);
      chk("repeat_queue_empty", q_exp.size(), 0);
    end

    // Continuous random run stopped on the 10th RUN cycle
    push_expected(2'b00, 10);
    do_start(2'b00, 16'd0);
    repeat (9) begin @(posedge clk); #1; end
    stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    @(negedge clk);
    chk("stop_done", done, 1'b1);
    chk("stop_valid", valid, 1'b0);
    chk("stop_count", xfer_count, 16'd10);
    chk("stop_queue_empty", q_exp.size(), 0);
    @(posedge clk); #1 start = 1'b1; stop = 1'b1;
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk("start_with_stop_ignored", busy, 1'b0);

    // Zero-length burst
    valid_cycles = 0;
    do_start(2'b01, 16'd0);
    wait_done(20, bc);
    chk("zero_busy_cycles", bc, 2);
    chk("zero_no_valid", valid_cycles, 0);
    chk("zero_count", xfer_count, 16'd0);

    // Sticky status accumulation, retention and clearing
    push_expected(2'b01, 6);
    do_start(2'b01, 16'd6);
    status = 4'b0100;
    @(posedge clk); #1 status = 4'b0000;
    @(posedge clk); #1 status = 4'b0001;
    @(posedge clk); #1 status = 4'b0000;
    wait_done(50, bc);
    chk("sticky_run", status_sticky, 4'b0101);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sticky_retained", status_sticky, 4'b0101);
    push_expected(2'b11, 2);
    do_start(2'b11, 16'd2);
    @(negedge clk);
    chk("sticky_cleared", status_sticky, 4'b0000);
    wait_done(50, bc);
    chk("inc2_queue_empty", q_exp.size(), 0);

    // Randomized bursts with random ready
    rand_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      rm = {1'($urandom_range(0, 1)), 1'b1};
      rl = CNT'($urandom_range(1, 12));
      push_expected(rm, int'(rl));
      do_start(rm, rl);
      wait_done(400, bc);
      chk("rand_count", xfer_count, rl);
      chk("rand_queue_empty", q_exp.size(), 0);
    end
    rand_ready = 1'b0;

    // Reset mid-burst: immediate clear, no done pulse
    push_expected(2'b01, 20);
    do_start(2'b01, 16'd20);
    repeat (3) begin @(posedge clk); #1; end
    done_seen = 0;
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {valid, busy, done, xfer_count, status_sticky, control_word, k}, '0);
    q_exp.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_no_done", done_seen, 0);
    chk("midrst_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
